// File: rtl/xor_checksum_pkg.sv
// xor_checksum_pkg: shared state encoding and width helper for the XOR checksum block
package xor_checksum_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int cw_of(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/xor_reduce.sv
// xor_reduce: combinational reduction XOR of a WIDTH-bit word
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ^data;

endmodule

// File: rtl/xor_checksum.sv
// xor_checksum: framed running XOR checksum with held result handshake
module xor_checksum
    import xor_checksum_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter int              MAX_LEN = 16,
    parameter logic [WIDTH-1:0] SEED   = '0,
    localparam int             CW      = cw_of(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_parity,
    output logic             out_err
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             par_nxt;
    logic             beat;
    logic             term;

    assign in_ready = (state != S_DONE);
    assign beat     = in_valid && in_ready;
    assign acc_nxt  = acc ^ in_data;
    assign cnt_nxt  = count + 1'b1;
    assign term     = in_last || (cnt_nxt == CW'(MAX_LEN));

    xor_reduce #(.WIDTH(WIDTH)) u_par (
        .data   (acc_nxt),
        .parity (par_nxt)
    );

    // frame FSM: accumulate beats, latch the result on the terminating beat, hold until taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            acc        <= SEED;
            count      <= '0;
            out_valid  <= 1'b0;
            out_data   <= SEED;
            out_count  <= '0;
            out_parity <= ^SEED;
            out_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (beat) begin
                        acc   <= acc_nxt;
                        count <= cnt_nxt;
                        if (term) begin
                            state      <= S_DONE;
                            out_valid  <= 1'b1;
                            out_data   <= acc_nxt;
                            out_count  <= cnt_nxt;
                            out_parity <= par_nxt;
                            out_err    <= !in_last;
                        end else begin
                            state <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        acc       <= SEED;
                        count     <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    acc       <= SEED;
                    count     <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
